// File: rtl/ctrl_pipe_multi.sv
// ctrl_pipe_multi: DEPTH-stage pipeline register for a WIDTH-bit control word.
// Each stage carries a valid bit. The pipe supports a global stall, a per-stage
// flush and bubble zeroing, so an empty stage always holds RST_VAL.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   stall_i      1 = hold every stage; in_* is not captured
//   flush_i      bit k = 1 -> stage k becomes a bubble at the next edge
//   in_valid     in_ctrl carries a real instruction
//   in_ctrl      control word entering stage 0
//   out_valid    valid bit of stage DEPTH-1
//   out_ctrl     control word of stage DEPTH-1
//   stage_valid  valid bit of every stage (bit k = stage k)
//   occupancy    registered count of valid stages
module ctrl_pipe_multi #(
    parameter int unsigned           WIDTH   = 3,
    parameter int unsigned           DEPTH   = 2,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_i,
    input  logic [DEPTH-1:0]              flush_i,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_ctrl,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_ctrl,
    output logic [DEPTH-1:0]              stage_valid,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] ctrl_q;
    logic [DEPTH-1:0][WIDTH-1:0] ctrl_d;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_d;
    logic [OCC_W-1:0]            occ_q;
    logic [OCC_W-1:0]            occ_d;

    // Per-stage next state: choose shift or hold, then let flush override it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             load_valid;
        logic [WIDTH-1:0] load_ctrl;

        if (g == 0) begin : g_head
            // Mask in_ctrl when it is not valid, so X or stale bits never enter the pipe.
            assign load_valid = in_valid;
            assign load_ctrl  = in_valid ? in_ctrl : RST_VAL;
        end else begin : g_body
            assign load_valid = valid_q[g-1];
            assign load_ctrl  = ctrl_q[g-1];
        end

        assign valid_d[g] = ~flush_i[g] & (stall_i ? valid_q[g] : load_valid);
        assign ctrl_d[g]  = flush_i[g] ? RST_VAL : (stall_i ? ctrl_q[g] : load_ctrl);
    end

    // Occupancy tracks the stage valids that are about to be written.
    always_comb begin
        occ_d = OCC_W'($countones(valid_d));
    end

    // Stage and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= {DEPTH{RST_VAL}};
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign out_valid   = valid_q[DEPTH-1];
    assign out_ctrl    = ctrl_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_ctrl_pipe_multi.sv
// Directed bench for ctrl_pipe_multi: a DEPTH=2 instance and a DEPTH=1 instance.
// The observation vectors are {out_valid, out_ctrl, stage_valid, occupancy}.
module tb_ctrl_pipe_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DEPTH = 2 instance
    logic       reset, stall, in_valid;
    logic [1:0] flush;
    logic [2:0] in_ctrl;
    logic       out_valid;
    logic [2:0] out_ctrl;
    logic [1:0] stage_valid;
    logic [1:0] occupancy;
    logic [7:0] obs2;
    logic [7:0] exp2;

    // DEPTH = 1 instance
    logic       reset1, stall1, in_valid1;
    logic [0:0] flush1;
    logic [2:0] in_ctrl1;
    logic       out_valid1;
    logic [2:0] out_ctrl1;
    logic [0:0] stage_valid1;
    logic [0:0] occupancy1;
    logic [5:0] obs1;
    logic [5:0] exp1;

    ctrl_pipe_multi #(.WIDTH(3), .DEPTH(2), .RST_VAL(3'b000)) dut2 (
        .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ctrl(out_ctrl), .stage_valid(stage_valid), .occupancy(occupancy)
    );

    ctrl_pipe_multi #(.WIDTH(3), .DEPTH(1), .RST_VAL(3'b000)) dut1 (
        .clk(clk), .reset(reset1), .stall_i(stall1), .flush_i(flush1),
        .in_valid(in_valid1), .in_ctrl(in_ctrl1), .out_valid(out_valid1),
        .out_ctrl(out_ctrl1), .stage_valid(stage_valid1), .occupancy(occupancy1)
    );

    assign obs2 = {out_valid, out_ctrl, stage_valid, occupancy};
    assign obs1 = {out_valid1, out_ctrl1, stage_valid1, occupancy1};

    // Advance one edge, then sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c);
        in_valid = v;
        in_ctrl  = c;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 2'b00; drive(1'b1, 3'b111);
        reset1 = 1'b1; stall1 = 1'b0; flush1 = 1'b0; in_valid1 = 1'b1; in_ctrl1 = 3'b111;
        tick(); tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL reset_d2 got=%b exp=%b", obs2, exp2); end
        exp1 = {1'b0, 3'b000, 1'b0, 1'd0};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL reset_d1 got=%b exp=%b", obs1, exp1); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        drive(1'b1, 3'b001); tick();
        exp2 = {1'b0, 3'b000, 2'b01, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stream_e1 got=%b exp=%b", obs2, exp2); end
        drive(1'b1, 3'b010); tick();
        exp2 = {1'b1, 3'b001, 2'b11, 2'd2};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stream_e2 got=%b exp=%b", obs2, exp2); end
        drive(1'b1, 3'b100); tick();
        exp2 = {1'b1, 3'b010, 2'b11, 2'd2};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stream_e3 got=%b exp=%b", obs2, exp2); end
        drive(1'b0, 3'b111); tick();
        exp2 = {1'b1, 3'b100, 2'b10, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stream_e4 got=%b exp=%b", obs2, exp2); end
        tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stream_e5 got=%b exp=%b", obs2, exp2); end
    endtask

    task automatic test_stall();
        drive(1'b1, 3'b001); tick();
        drive(1'b1, 3'b010); tick();
        stall = 1'b1; drive(1'b1, 3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp2 = {1'b1, 3'b001, 2'b11, 2'd2};
            checks++;
            if (obs2 !== exp2) begin failures++; $display("FAIL stall_hold%0d got=%b exp=%b", i, obs2, exp2); end
        end
        stall = 1'b0; drive(1'b0, 3'b000); tick();
        exp2 = {1'b1, 3'b010, 2'b10, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stall_release got=%b exp=%b", obs2, exp2); end
        tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL stall_no_capture got=%b exp=%b", obs2, exp2); end
    endtask

    task automatic test_bubble();
        drive(1'b1, 3'b101); tick();
        drive(1'b0, 3'b111); tick();
        exp2 = {1'b1, 3'b101, 2'b10, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL bubble_e2 got=%b exp=%b", obs2, exp2); end
        drive(1'b0, 3'bxxx); tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL bubble_zero got=%b exp=%b", obs2, exp2); end
        tick();
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL bubble_xmask got=%b exp=%b", obs2, exp2); end
        drive(1'b0, 3'b000);
    endtask

    task automatic test_flush();
        drive(1'b1, 3'b001); tick();
        drive(1'b1, 3'b010); tick();
        stall = 1'b1; flush = 2'b10; drive(1'b1, 3'b111); tick();
        exp2 = {1'b0, 3'b000, 2'b01, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL flush_stalled got=%b exp=%b", obs2, exp2); end
        stall = 1'b0; flush = 2'b01; drive(1'b1, 3'b100); tick();
        exp2 = {1'b1, 3'b010, 2'b10, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL flush_kill_in got=%b exp=%b", obs2, exp2); end
        flush = 2'b00; drive(1'b0, 3'b000); tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL flush_discarded got=%b exp=%b", obs2, exp2); end
        // Flush only the output stage while shifting: the word moving into it dies.
        drive(1'b1, 3'b011); tick();
        drive(1'b1, 3'b110); tick();
        flush = 2'b10; drive(1'b1, 3'b001); tick();
        exp2 = {1'b0, 3'b000, 2'b01, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL flush_out_stage got=%b exp=%b", obs2, exp2); end
        flush = 2'b00; drive(1'b0, 3'b000); tick();
        exp2 = {1'b1, 3'b001, 2'b10, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL flush_survivor got=%b exp=%b", obs2, exp2); end
        // Flush both stages while a valid word is arriving.
        drive(1'b1, 3'b011); tick();
        flush = 2'b11; drive(1'b1, 3'b111); tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL flush_all got=%b exp=%b", obs2, exp2); end
        flush = 2'b00; drive(1'b0, 3'b000);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b011); tick();
        drive(1'b1, 3'b110); tick();
        reset = 1'b1; drive(1'b1, 3'b111); tick();
        exp2 = {1'b0, 3'b000, 2'b00, 2'd0};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL midreset got=%b exp=%b", obs2, exp2); end
        reset = 1'b0; drive(1'b1, 3'b101); tick();
        exp2 = {1'b0, 3'b000, 2'b01, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL midreset_cap got=%b exp=%b", obs2, exp2); end
        drive(1'b1, 3'b010); tick();
        exp2 = {1'b1, 3'b101, 2'b11, 2'd2};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL b2b_e2 got=%b exp=%b", obs2, exp2); end
        drive(1'b0, 3'b000); tick();
        exp2 = {1'b1, 3'b010, 2'b10, 2'd1};
        checks++;
        if (obs2 !== exp2) begin failures++; $display("FAIL b2b_e3 got=%b exp=%b", obs2, exp2); end
    endtask

    task automatic test_depth1();
        reset1 = 1'b0; in_valid1 = 1'b1; in_ctrl1 = 3'b110; tick();
        exp1 = {1'b1, 3'b110, 1'b1, 1'd1};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL d1_capture got=%b exp=%b", obs1, exp1); end
        reset1 = 1'b1; in_ctrl1 = 3'b111; tick();
        exp1 = {1'b0, 3'b000, 1'b0, 1'd0};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL d1_reset got=%b exp=%b", obs1, exp1); end
        reset1 = 1'b0; in_ctrl1 = 3'b101; tick();
        exp1 = {1'b1, 3'b101, 1'b1, 1'd1};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL d1_latency got=%b exp=%b", obs1, exp1); end
        flush1 = 1'b1; in_ctrl1 = 3'b011; tick();
        exp1 = {1'b0, 3'b000, 1'b0, 1'd0};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL d1_flush got=%b exp=%b", obs1, exp1); end
        flush1 = 1'b0; in_ctrl1 = 3'b010; tick();
        stall1 = 1'b1; in_ctrl1 = 3'b111; tick();
        exp1 = {1'b1, 3'b010, 1'b1, 1'd1};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL d1_stall got=%b exp=%b", obs1, exp1); end
        stall1 = 1'b0; in_valid1 = 1'b0; tick();
        exp1 = {1'b0, 3'b000, 1'b0, 1'd0};
        checks++;
        if (obs1 !== exp1) begin failures++; $display("FAIL d1_drain got=%b exp=%b", obs1, exp1); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
